// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, ALU op codes and forwarding selects for the ID/EX stage
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_ADD2 = 4'd3,
        ALU_SUB2 = 4'd4,
        ALU_MUL  = 4'd5,
        ALU_DIV  = 4'd6,
        ALU_OR   = 4'd7,
        ALU_AND  = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_SLL  = 4'd10,
        ALU_SRL  = 4'd11,
        ALU_SLT  = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXM,
        FWD_MWB
    } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass select: r0, EX/MEM, MEM/WB, then register file value
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RA_W-1:0] src,
    input  logic [XLEN-1:0] reg_val,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] operand
);

    fwd_sel_t sel;

    // The younger producer (EX/MEM) wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        sel = FWD_REG;
        if (src != '0) begin
            if (exm_reg_write && exm_rd == src)
                sel = FWD_EXM;
            else if (mwb_reg_write && mwb_rd == src)
                sel = FWD_MWB;
        end
    end

    always_comb begin
        case (sel)
            FWD_EXM: operand = exm_result;
            FWD_MWB: operand = mwb_result;
            default: operand = (src == '0) ? '0 : reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register with forwarding, load-use bubbles and flush; optional ID_EX_DIV0_TRAP_EN
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_alu_decode,
    input  logic [RA_W-1:0] in_rs_a,
    input  logic [RA_W-1:0] in_rs_x,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_reg_a,
    input  logic [XLEN-1:0] in_reg_x,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_decode,
    output logic [XLEN-1:0] rda,
    output logic [XLEN-1:0] rdx,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_is_load
`ifdef ID_EX_DIV0_TRAP_EN
    ,
    output logic            div0_trap
`endif
);

    logic            v_q;
    alu_op_t         dec_q;
    logic [RA_W-1:0] rs_a_q, rs_x_q, rd_q;
    logic [XLEN-1:0] reg_a_q, reg_x_q, imm_q;
    logic            use_imm_q, reg_write_q, is_load_q;

    logic            load_use, advance, accept, trap;
    logic [XLEN-1:0] fwd_x;

    // A load's data is not ready until after MEM, so a dependent op must wait one slot.
    assign load_use = v_q && is_load_q && (rd_q != '0) && in_valid &&
                      ((rd_q == in_rs_a) || (!in_use_imm && rd_q == in_rs_x));
    assign advance  = !v_q || out_ready;
    assign in_ready = advance && !load_use && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= 1'b0;
            dec_q       <= ALU_NOP;
            rs_a_q      <= '0;
            rs_x_q      <= '0;
            rd_q        <= '0;
            reg_a_q     <= '0;
            reg_x_q     <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            is_load_q   <= 1'b0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (advance) begin
            v_q <= accept;
            if (accept) begin
                dec_q       <= alu_op_t'(in_alu_decode);
                rs_a_q      <= in_rs_a;
                rs_x_q      <= in_rs_x;
                rd_q        <= in_rd;
                reg_a_q     <= in_reg_a;
                reg_x_q     <= in_reg_x;
                imm_q       <= in_imm;
                use_imm_q   <= in_use_imm;
                reg_write_q <= in_reg_write;
                is_load_q   <= in_is_load;
            end
        end
    end

    fwd_mux u_fwd_a (
        .src           (rs_a_q),
        .reg_val       (reg_a_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .operand       (rda)
    );

    fwd_mux u_fwd_x (
        .src           (rs_x_q),
        .reg_val       (reg_x_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .operand       (fwd_x)
    );

    assign rdx = use_imm_q ? imm_q : fwd_x;

`ifdef ID_EX_DIV0_TRAP_EN
    // A trapping DIV still retires in order but must neither compute nor write back.
    assign trap      = v_q && (dec_q == ALU_DIV) && (rdx == '0);
    assign div0_trap = trap;
`else
    assign trap      = 1'b0;
`endif

    assign out_valid     = v_q;
    assign alu_decode    = (v_q && !trap) ? dec_q : 4'b0000;
    assign out_rd        = rd_q;
    assign out_reg_write = v_q && reg_write_q && !trap;
    assign out_is_load   = v_q && is_load_q;

endmodule
